vga_timing_gen: RTL and testbench

Generates 640x480 @ 60 Hz VGA timing from the 50 MHz system clock. Divides the system clock by two into the 25 MHz pixel clock. Runs horizontal and vertical counters and drives hs, vs, blank, DrawX and DrawY. It is the stage directly upstream of the per-level background renderers and the sprite/colour mappers, which consume pixel_clk (as vga_clk), DrawX, DrawY and blank.

---
 rtl/vga_timing_gen.sv | 78 +++++++
 tb/tb_vga_timing_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: divides Clk by two into pixel_clk and scans
// the horizontal/vertical counters, decoding registered sync, blank and position.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_TOTAL   = 800,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOTAL   = 525
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixel_clk,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] hc;
    logic [9:0] vc;
    logic [9:0] hc_next;
    logic [9:0] vc_next;
    logic       h_wrap;

    // Wrap by equality so the counters can never run past the last position.
    always_comb begin
        h_wrap  = (hc == H_LAST);
        hc_next = h_wrap ? 10'd0 : hc + 10'd1;
        vc_next = vc;
        if (h_wrap) begin
            vc_next = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pixel_clk   <= 1'b0;
            hc          <= 10'd0;
            vc          <= 10'd0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            pixel_clk   <= ~pixel_clk;
            frame_start <= 1'b0;
            // Advance on the pixel_clk falling edge; decodes use the new position.
            if (pixel_clk) begin
                hc          <= hc_next;
                vc          <= vc_next;
                hs          <= !((hc_next >= HS_START) && (hc_next < HS_END));
                vs          <= !((vc_next >= VS_START) && (vc_next < VS_END));
                blank       <= (hc_next < H_VIS) && (vc_next < V_VIS);
                frame_start <= (hc_next == 10'd0) && (vc_next == 10'd0);
            end
        end
    end

    assign DrawX = hc;
    assign DrawY = vc;
    assign sync  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-size and a shrunk-parameter instance share one
// clock; a position model indexed by edges-since-reset feeds the expected queues.
module tb_vga_timing_gen;

    localparam int W = 26;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_alt = 1'b1;

    logic       pclk, hs, vs, blank, sync, fs;
    logic [9:0] draw_x, draw_y;
    logic       a_pclk, a_hs, a_vs, a_blank, a_sync, a_fs;
    logic [9:0] a_draw_x, a_draw_y;

    int tests = 0;
    int fails = 0;
    int n_def = 0;
    int n_alt = 0;
    int cyc = 0;
    int last_fs = -1;
    int hs_low = 0;
    int a_hs_low = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_alt_q[$];

    typedef struct {
        bit         alt;
        int         n;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       fs;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl[NV];

    vga_timing_gen dut (
        .Clk(clk), .Reset(rst), .pixel_clk(pclk), .hs(hs), .vs(vs), .blank(blank),
        .sync(sync), .DrawX(draw_x), .DrawY(draw_y), .frame_start(fs)
    );

    vga_timing_gen #(
        .H_VISIBLE(10), .H_FP(2), .H_SYNC(3), .H_TOTAL(20),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_TOTAL(8)
    ) dut_alt (
        .Clk(clk), .Reset(rst_alt), .pixel_clk(a_pclk), .hs(a_hs), .vs(a_vs), .blank(a_blank),
        .sync(a_sync), .DrawX(a_draw_x), .DrawY(a_draw_y), .frame_start(a_fs)
    );

    // ---------------- clock ----------------
    always #10 clk = ~clk;

    // ---------------- model ----------------
    // State after n Clk edges since reset, derived from the absolute pixel index.
    function automatic logic [W-1:0] model(input int n, input int hv, input int hfp, input int hsw,
                                           input int ht, input int vv, input int vfp, input int vsw,
                                           input int vt);
        int pos, x, y;
        logic p, h, v, b, f;
        pos = n / 2;
        x = pos % ht;
        y = (pos / ht) % vt;
        p = (n % 2) == 1;
        f = (n > 0) && (n % 2 == 0) && (pos % (ht * vt) == 0);
        h = !(x >= hv + hfp && x < hv + hfp + hsw);
        v = !(y >= vv + vfp && y < vv + vfp + vsw);
        b = (x < hv) && (y < vv);
        return {p, h, v, b, 1'b0, f, 10'(x), 10'(y)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        cyc++;
        n_def = rst ? 0 : n_def + 1;
        n_alt = rst_alt ? 0 : n_alt + 1;
        if (rst_alt) last_fs = -1;
        exp_q.push_back(model(n_def, 640, 16, 96, 800, 480, 10, 2, 525));
        exp_alt_q.push_back(model(n_alt, 10, 2, 3, 20, 4, 1, 1, 8));
    end

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_def", 32'({pclk, hs, vs, blank, sync, fs, draw_x, draw_y}), 32'(e));
        end
        if (exp_alt_q.size() > 0) begin
            e = exp_alt_q.pop_front();
            check("sb_alt", 32'({a_pclk, a_hs, a_vs, a_blank, a_sync, a_fs, a_draw_x, a_draw_y}), 32'(e));
        end
        // hs low pulse widths in Clk periods
        if (hs === 1'b0) hs_low++;
        else if (hs_low != 0) begin
            check("hs_width_def", 32'(hs_low), 32'd192);
            hs_low = 0;
        end
        if (a_hs === 1'b0) a_hs_low++;
        else if (a_hs_low != 0) begin
            check("hs_width_alt", 32'(a_hs_low), 32'd6);
            a_hs_low = 0;
        end
        if (a_fs === 1'b1) begin
            if (last_fs >= 0) check("fs_period_alt", 32'(cyc - last_fs), 32'd320);
            last_fs = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_n(input bit alt, input int target);
        int guard = 0;
        while ((alt ? n_alt : n_def) < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if ((alt ? n_alt : n_def) < target) begin
            tests++;
            fails++;
            $display("FAIL wait_n: reached %0d required %0d", alt ? n_alt : n_def, target);
        end
    endtask

    initial begin
        tbl[0]  = '{0,    2, 10'd1,   10'd0, 1, 1, 1, 0};
        tbl[1]  = '{1,    2, 10'd1,   10'd0, 1, 1, 1, 0};
        tbl[2]  = '{1,   22, 10'd11,  10'd0, 1, 1, 0, 0};
        tbl[3]  = '{1,   24, 10'd12,  10'd0, 0, 1, 0, 0};
        tbl[4]  = '{1,   28, 10'd14,  10'd0, 0, 1, 0, 0};
        tbl[5]  = '{1,   30, 10'd15,  10'd0, 1, 1, 0, 0};
        tbl[6]  = '{1,  198, 10'd19,  10'd4, 1, 1, 0, 0};
        tbl[7]  = '{1,  200, 10'd0,   10'd5, 1, 0, 0, 0};
        tbl[8]  = '{1,  240, 10'd0,   10'd6, 1, 1, 0, 0};
        tbl[9]  = '{1,  320, 10'd0,   10'd0, 1, 1, 1, 1};
        tbl[10] = '{1,  322, 10'd1,   10'd0, 1, 1, 1, 0};
        tbl[11] = '{0, 1278, 10'd639, 10'd0, 1, 1, 1, 0};
        tbl[12] = '{0, 1280, 10'd640, 10'd0, 1, 1, 0, 0};
        tbl[13] = '{0, 1310, 10'd655, 10'd0, 1, 1, 0, 0};
        tbl[14] = '{0, 1312, 10'd656, 10'd0, 0, 1, 0, 0};
        tbl[15] = '{0, 1502, 10'd751, 10'd0, 0, 1, 0, 0};
        tbl[16] = '{0, 1504, 10'd752, 10'd0, 1, 1, 0, 0};
        tbl[17] = '{0, 1598, 10'd799, 10'd0, 1, 1, 0, 0};
        tbl[18] = '{0, 1600, 10'd0,   10'd1, 1, 1, 1, 0};

        // Reset held: everything frozen at the reset state.
        repeat (5) @(negedge clk);
        check("reset_hold_def", 32'({pclk, hs, vs, blank, sync, fs, draw_x, draw_y}),
              32'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0}));
        check("reset_hold_alt", 32'({a_pclk, a_hs, a_vs, a_blank, a_sync, a_fs, a_draw_x, a_draw_y}),
              32'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0}));
        rst = 1'b0;
        rst_alt = 1'b0;

        for (int i = 0; i < NV; i++) begin
            wait_n(0, tbl[i].n);
            if (tbl[i].alt)
                check($sformatf("vec%0d", i), 32'({a_draw_x, a_draw_y, a_hs, a_vs, a_blank, a_fs}),
                      32'({tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].blank, tbl[i].fs}));
            else
                check($sformatf("vec%0d", i), 32'({draw_x, draw_y, hs, vs, blank, fs}),
                      32'({tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].blank, tbl[i].fs}));
        end

        // Mid-frame reset on the small instance at (7,2) with pixel_clk high.
        wait_n(1, 3615);
        check("pre_rst_alt", 32'({a_pclk, a_draw_x, a_draw_y}), 32'({1'b1, 10'd7, 10'd2}));
        rst_alt = 1'b1;
        @(negedge clk);
        check("mid_rst_alt", 32'({a_pclk, a_hs, a_vs, a_blank, a_fs, a_draw_x, a_draw_y}),
              32'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0}));
        rst_alt = 1'b0;

        // Mid-frame reset on the full-size instance at (300,2) with pixel_clk high.
        wait_n(0, 3801);
        check("pre_rst_def", 32'({pclk, draw_x, draw_y}), 32'({1'b1, 10'd300, 10'd2}));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_def", 32'({pclk, hs, vs, blank, fs, draw_x, draw_y}),
              32'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0}));
        rst = 1'b0;
        wait_n(0, 2);
        check("resume_def", 32'({draw_x, draw_y}), 32'({10'd1, 10'd0}));

        wait_n(0, 3400);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
